multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter ENABLE_LUI, default 1; when 1, lui (Op 0110111) is decoded as legal.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports Op (input, 7 bits: Instr[6:0]), Funct3 (input, 3 bits: Instr[14:12]) and Funct7b5 (input, 1 bit: Instr[30]).
REQ-005 The block SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-006 The block SHALL have ports PCWrite, IRWrite, MemWrite, RegWrite and AdrSrc: outputs, 1 bit each; strobes and the memory address select (0 = PC, 1 = Result).
REQ-007 The block SHALL have ports ResultSrc, ALUSrcA and ALUSrcB: outputs, 2 bits each; mux selects.
REQ-008 The block SHALL have port ALUControl, output, 3 bits: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-009 The block SHALL have port ImmSrc, output, 3 bits, feeding the immediate extender: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-010 The block SHALL have ports State (output, 4 bits: current state encoding) and Illegal (output, 1 bit: one-cycle pulse on an unsupported opcode).

Function
REQ-011 The state encoding SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-012 The transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR for Op 0000011 or 0100011.
- DECODE->EXECUTER for 0110011.
- DECODE->EXECUTEI for 0010011.
- DECODE->JAL for 1101111.
- DECODE->BEQ for 1100011.
- DECODE->LUI for 0110111 when ENABLE_LUI=1.
- DECODE->FETCH for any other Op.
REQ-013 Further transitions SHALL be:
- MEMADR->MEMREAD if Op=0000011, else MEMWRITE.
- MEMREAD->MEMWB->FETCH.
- MEMWRITE->FETCH.
- EXECUTER, EXECUTEI, JAL and LUI ->ALUWB.
- ALUWB->FETCH.
- BEQ->FETCH.
REQ-014 Outputs SHALL be Moore-decoded from State; every field not listed for a state is 0.
REQ-015 FETCH outputs SHALL be: IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10, ALUOp=add.
REQ-016 DECODE outputs SHALL be ALUSrcA=01, ALUSrcB=01; MEMADR outputs SHALL be ALUSrcA=10, ALUSrcB=01.
REQ-017 Memory-state outputs SHALL be: MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1; MEMWRITE AdrSrc=1, MemWrite=1.
REQ-018 Execute-state outputs SHALL be: EXECUTER ALUSrcA=10, ALUOp=funct; EXECUTEI ALUSrcA=10, ALUSrcB=01, ALUOp=funct; ALUWB RegWrite=1.
REQ-019 Control-flow outputs SHALL be: JAL ALUSrcA=01, ALUSrcB=10, PCUpdate=1; BEQ ALUSrcA=10, ALUOp=sub, Branch=1; LUI ALUSrcA=11 (zero), ALUSrcB=01.
REQ-020 PCWrite SHALL equal PCUpdate OR (Branch AND (Zero XOR Funct3[0])), so that Funct3=001 (bne) inverts the condition.
REQ-021 ALUControl SHALL be 000 for ALUOp=add and 001 for ALUOp=sub.
REQ-022 For ALUOp=funct, ALUControl SHALL be:
- Funct3 000: 001 if Op[5]=1 AND Funct7b5=1, else 000.
- Funct3 010: 101.
- Funct3 110: 011.
- Funct3 111: 010.
- Any other Funct3: 000.
REQ-023 ImmSrc SHALL be combinational from Op in every state: 0100011->001, 1100011->010, 1101111->011, 0110111->100, all others->000.
REQ-024 Illegal SHALL be 1 exactly during a DECODE cycle whose Op takes the DECODE->FETCH path.
REQ-025 Each instruction SHALL take: lw 5 cycles, sw 4, R/I-ALU 4, jal 4, lui 4, beq/bne 3.

Reset
REQ-026 rst_n=0 SHALL force State to FETCH immediately, without waiting for a clock edge.
REQ-027 While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite and Illegal SHALL be 0.
REQ-028 Reset asserted mid-instruction SHALL abandon that instruction with no further write strobes.
REQ-029 The first rising edge after rst_n rises SHALL occur in FETCH, with IRWrite=1 and PCWrite=1.

Verification
REQ-030 Reset, then lw (Op 0000011): State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; ImmSrc=000 throughout.
REQ-031 sw (Op 0100011): sequence 0,1,2,5,0; MemWrite=1 only in state 5; AdrSrc=1 in state 5; ImmSrc=001.
REQ-032 beq with Zero=1 gives PCWrite=1 in state 9; Zero=0 gives PCWrite=0; bne (Funct3=001) with Zero=0 gives PCWrite=1; ALUControl=001 and ImmSrc=010 in state 9.
REQ-033 R-type with Funct3=000, Funct7b5=1 gives ALUControl=001 in state 6; I-type with the same fields gives ALUControl=000 in state 7.
REQ-034 Op=1111111 gives State 0,1,0 and Illegal=1 for exactly the DECODE cycle.
REQ-035 With ENABLE_LUI=0, lui gives the same response as REQ-034; with ENABLE_LUI=1, lui gives State 0,1,11,8,0, ImmSrc=100, and ALUSrcA=11 in state 11.
REQ-036 rst_n pulsed low during MEMWRITE: State=0 and MemWrite=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RISC-V core.
// Moore controls are registered alongside the state; strobes are gated by rst_n.
module multicycle_ctrl #(
    parameter bit ENABLE_LUI = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic [3:0] State,
    output logic       Illegal
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7,
        ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, LUI = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       adrsrc;
        logic [1:0] resultsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
    } ctl_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_FN  = 2'd2;

    function automatic state_t next_of(input state_t s, input logic [6:0] op);
        case (s)
            FETCH:    next_of = DECODE;
            DECODE:   next_of = (op == OP_LW || op == OP_SW) ? MEMADR :
                                op == OP_R   ? EXECUTER :
                                op == OP_I   ? EXECUTEI :
                                op == OP_JAL ? JAL :
                                op == OP_BEQ ? BEQ :
                                (ENABLE_LUI && op == OP_LUI) ? LUI : FETCH;
            MEMADR:   next_of = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_of = MEMWB;
            EXECUTER, EXECUTEI, JAL, LUI: next_of = ALUWB;
            default:  next_of = FETCH;
        endcase
    endfunction

    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.irwrite = 1'b1; c.pcupdate = 1'b1; c.srcb = 2'b10; c.resultsrc = 2'b10; end
            DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
            MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
            MEMREAD:  c.adrsrc = 1'b1;
            MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
            MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
            EXECUTER: begin c.srca = 2'b10; c.aluop = ALU_FN; end
            EXECUTEI: begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = ALU_FN; end
            ALUWB:    c.regwrite = 1'b1;
            JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcupdate = 1'b1; end
            BEQ:      begin c.srca = 2'b10; c.aluop = ALU_SUB; c.branch = 1'b1; end
            LUI:      begin c.srca = 2'b11; c.srcb = 2'b01; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t     state, nxt;
    ctl_t       ctl;
    logic [2:0] fn_ctl;

    assign nxt = next_of(state, Op);

    // Controls are loaded with the decode of the incoming state, so they always match State.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ctl   <= ctl_of(FETCH);
        end else begin
            state <= nxt;
            ctl   <= ctl_of(nxt);
        end
    end

    always_comb begin
        fn_ctl = Funct3 == 3'b000 ? ((Op[5] && Funct7b5) ? 3'b001 : 3'b000) :
                 Funct3 == 3'b010 ? 3'b101 :
                 Funct3 == 3'b110 ? 3'b011 :
                 Funct3 == 3'b111 ? 3'b010 : 3'b000;
        ALUControl = ctl.aluop == ALU_FN ? fn_ctl : ctl.aluop == ALU_SUB ? 3'b001 : 3'b000;
        ImmSrc = Op == OP_SW  ? 3'b001 :
                 Op == OP_BEQ ? 3'b010 :
                 Op == OP_JAL ? 3'b011 :
                 Op == OP_LUI ? 3'b100 : 3'b000;
    end

    // bne is Funct3=001: its low bit flips the branch sense.
    assign PCWrite   = rst_n & (ctl.pcupdate | (ctl.branch & (Zero ^ Funct3[0])));
    assign IRWrite   = rst_n & ctl.irwrite;
    assign MemWrite  = rst_n & ctl.memwrite;
    assign RegWrite  = rst_n & ctl.regwrite;
    assign AdrSrc    = ctl.adrsrc;
    assign ResultSrc = ctl.resultsrc;
    assign ALUSrcA   = ctl.srca;
    assign ALUSrcB   = ctl.srcb;
    assign State     = state;
    assign Illegal   = rst_n & (state == DECODE) & (nxt == FETCH);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked each cycle against
// a per-instruction state-sequence model, plus directed literal checks.
module tb_multicycle_ctrl;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] JL = 7'b1101111, BQ = 7'b1100011, LU = 7'b0110111, BAD = 7'b1111111;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, zero;
    logic pcw, irw, mw, rw, adr, ill;
    logic [1:0] res, sa, sb;
    logic [2:0] ac, im;
    logic [3:0] st;
    logic pcw1, irw1, mw1, rw1, adr1, ill1;
    logic [1:0] res1, sa1, sb1;
    logic [2:0] ac1, im1;
    logic [3:0] st1;

    multicycle_ctrl #(.ENABLE_LUI(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .Op(op), .Funct3(f3), .Funct7b5(f7), .Zero(zero),
        .PCWrite(pcw), .IRWrite(irw), .MemWrite(mw), .RegWrite(rw), .AdrSrc(adr),
        .ResultSrc(res), .ALUSrcA(sa), .ALUSrcB(sb), .ALUControl(ac), .ImmSrc(im),
        .State(st), .Illegal(ill));

    multicycle_ctrl #(.ENABLE_LUI(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .Op(op), .Funct3(f3), .Funct7b5(f7), .Zero(zero),
        .PCWrite(pcw1), .IRWrite(irw1), .MemWrite(mw1), .RegWrite(rw1), .AdrSrc(adr1),
        .ResultSrc(res1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUControl(ac1), .ImmSrc(im1),
        .State(st1), .Illegal(ill1));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit run = 1'b0;
    typedef struct { int s0; int s1; } e_t;
    e_t q[$];
    int sn_st[8], sn_st1[8], sn_ac[8], sn_pcw[8], sn_ill[8], sn_ill1[8], sn_sa[8], sn_rw[8], sn_mw[8], sn_im[8];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic bit legal(input logic [6:0] o, input bit en);
        return o == LW || o == SW || o == RT || o == IT || o == JL || o == BQ || (en && o == LU);
    endfunction

    // Whole-instruction state walk, straight from the instruction timing table.
    function automatic void seq_of(input logic [6:0] o, input bit en, output int s[$]);
        if (o == LW) s = '{0, 1, 2, 3, 4};
        else if (o == SW) s = '{0, 1, 2, 5};
        else if (o == RT) s = '{0, 1, 6, 8};
        else if (o == IT) s = '{0, 1, 7, 8};
        else if (o == JL) s = '{0, 1, 10, 8};
        else if (o == BQ) s = '{0, 1, 9};
        else if (en && o == LU) s = '{0, 1, 11, 8};
        else s = '{0, 1};
    endfunction

    function automatic logic [2:0] aluf(input logic [6:0] o, input logic [2:0] fn, input logic b5);
        case (fn)
            3'b000:  return (o[5] && b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [17:0] exp_vec(input int s, input logic [6:0] o, input logic [2:0] fn,
                                            input logic b5, input logic z);
        logic [1:0] r, a, b;
        logic [2:0] c, i;
        r = s == 0 ? 2'd2 : s == 4 ? 2'd1 : 2'd0;
        a = (s == 1 || s == 10) ? 2'd1 : (s == 2 || s == 6 || s == 7 || s == 9) ? 2'd2 : s == 11 ? 2'd3 : 2'd0;
        b = (s == 0 || s == 10) ? 2'd2 : (s == 1 || s == 2 || s == 7 || s == 11) ? 2'd1 : 2'd0;
        c = s == 9 ? 3'b001 : (s == 6 || s == 7) ? aluf(o, fn, b5) : 3'b000;
        i = o == SW ? 3'd1 : o == BQ ? 3'd2 : o == JL ? 3'd3 : o == LU ? 3'd4 : 3'd0;
        return {s == 0 || s == 10 || (s == 9 && (z ^ fn[0])), s == 0, s == 5, s == 4 || s == 8,
                s == 3 || s == 5, r, a, b, c, i, s == 1 && !legal(o, 1'b1)};
    endfunction

    always @(negedge clk) begin
        if (run) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL model_queue empty t=%0t", $time);
            end else begin
                e_t e;
                e = q.pop_front();
                chk("state", st, e.s0);
                chk("outputs", {pcw, irw, mw, rw, adr, res, sa, sb, ac, im, ill}, exp_vec(e.s0, op, f3, f7, zero));
                chk("state_nolui", st1, e.s1);
                chk("illegal_nolui", ill1, e.s1 == 1 && !legal(op, 1'b0));
            end
        end
    end

    // Drives one instruction (zm: 0/1 fixed Zero, 2 random) and snapshots outputs per cycle.
    task automatic issue(input logic [6:0] o, input logic [2:0] fn, input logic b5, input int zm);
        int s0[$], s1[$], t[$];
        op = o; f3 = fn; f7 = b5;
        seq_of(o, 1'b1, s0);
        seq_of(o, 1'b0, t);
        s1 = t;
        while (s1.size() < s0.size()) s1 = {s1, t};
        foreach (s0[i]) q.push_back('{s0[i], s1[i]});
        foreach (s0[i]) begin
            zero = zm == 2 ? 1'($urandom) : zm[0];
            #1;
            sn_st[i] = st; sn_st1[i] = st1; sn_ac[i] = ac; sn_pcw[i] = pcw; sn_ill[i] = ill;
            sn_ill1[i] = ill1; sn_sa[i] = sa; sn_rw[i] = rw; sn_mw[i] = mw; sn_im[i] = im;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [6:0] ops[8];
        logic [6:0] o;
        ops = '{LW, SW, RT, IT, JL, BQ, LU, BAD};
        op = LW; f3 = 3'b0; f7 = 1'b0; zero = 1'b0;
        #12;
        chk("rst_state", st, 0);
        chk("rst_strobes", {pcw, irw, mw, rw, ill}, 5'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_irwrite", irw, 1);
        chk("post_rst_pcwrite", pcw, 1);
        run = 1'b1;
        issue(LW, 3'b010, 1'b0, 2);
        chk("lw_seq", {sn_st[0][3:0], sn_st[1][3:0], sn_st[2][3:0], sn_st[3][3:0], sn_st[4][3:0]}, 20'h01234);
        chk("lw_regwrite", {sn_rw[0][0], sn_rw[1][0], sn_rw[2][0], sn_rw[3][0], sn_rw[4][0]}, 5'b00001);
        issue(SW, 3'b010, 1'b0, 2);
        chk("sw_seq", {sn_st[0][3:0], sn_st[1][3:0], sn_st[2][3:0], sn_st[3][3:0]}, 16'h0125);
        chk("sw_memwrite", {sn_mw[0][0], sn_mw[1][0], sn_mw[2][0], sn_mw[3][0]}, 4'b0001);
        chk("sw_imm", sn_im[0], 1);
        issue(BQ, 3'b000, 1'b0, 1);
        chk("beq_taken", sn_pcw[2], 1);
        chk("beq_aluc", sn_ac[2], 1);
        chk("beq_imm", sn_im[2], 2);
        issue(BQ, 3'b000, 1'b0, 0);
        chk("beq_not_taken", sn_pcw[2], 0);
        issue(BQ, 3'b001, 1'b0, 0);
        chk("bne_taken", sn_pcw[2], 1);
        issue(RT, 3'b000, 1'b1, 2);
        chk("r_sub_aluc", sn_ac[2], 1);
        issue(IT, 3'b000, 1'b1, 2);
        chk("i_add_aluc", sn_ac[2], 0);
        issue(BAD, 3'b000, 1'b0, 2);
        chk("bad_seq", {sn_st[0][3:0], sn_st[1][3:0]}, 8'h01);
        chk("bad_illegal", {sn_ill[0][0], sn_ill[1][0]}, 2'b01);
        issue(LU, 3'b000, 1'b0, 2);
        chk("lui_seq", {sn_st[0][3:0], sn_st[1][3:0], sn_st[2][3:0], sn_st[3][3:0]}, 16'h01b8);
        chk("lui_srca", sn_sa[2], 3);
        chk("lui_imm", sn_im[0], 4);
        chk("nolui_seq", {sn_st1[0][3:0], sn_st1[1][3:0], sn_st1[2][3:0]}, 12'h010);
        chk("nolui_illegal", sn_ill1[1], 1);
        for (int n = 0; n < 300; n++) begin
            o = ops[$urandom_range(0, 7)];
            if (o == BAD) begin
                o = 7'($urandom);
                while (legal(o, 1'b1) || o == LU) o = 7'($urandom);
            end
            issue(o, 3'($urandom), 1'($urandom), 2);
        end
        run = 1'b0;
        op = SW; f3 = 3'b010;
        repeat (3) @(posedge clk);
        #2;
        chk("memwrite_before_rst", {st, mw}, {4'd5, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", st, 0);
        chk("async_rst_strobes", {pcw, irw, mw, rw, ill}, 5'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rerelease_fetch", {st, irw, pcw}, {4'd0, 1'b1, 1'b1});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
